// File: rtl/cmp_search.sv
// cmp_search: sequential binary-search initiator for the magnitude comparator.
//
// Drives a trial operand on `guess` (comparator input a; the hidden target is on b),
// reads back the one-hot result (x: a>b, y: a<b, z: a==b) and narrows [lo, hi] each
// acked step until equality is reported. On success `found`/`done` are produced. If the
// responses are inconsistent, `fail` is pulsed instead.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a search (sampled only in IDLE)
//   guess, cmp_req    registered trial operand and its request strobe
//   cmp_ack           comparator result valid this cycle
//   res_x/y/z         comparator result (guess > / < / == target)
//   busy              search in progress
//   done, fail        one-cycle completion / abort pulses
//   found             last matched value, held until the next done
//   steps             acked comparisons in the current or last search
//
// Build option:
//   CMP_SEARCH_ONEHOT_CHECK_EN  when defined, any acked result that is not exactly
//                               one-hot aborts the search. Otherwise the result is
//                               priority-decoded z > x > y and only all-zero aborts.
//
// state | meaning
// IDLE  | waiting for start; busy=0, cmp_req=0
// REQ   | guess presented, waiting for cmp_ack; busy=1, cmp_req=1

module cmp_search #(
    parameter int W  = 4,
    parameter int SW = $clog2(W + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [W-1:0]  guess,
    output logic          cmp_req,
    input  logic          cmp_ack,
    input  logic          res_x,
    input  logic          res_y,
    input  logic          res_z,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [W-1:0]  found,
    output logic [SW-1:0] steps
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [W-1:0] ALL_ONES    = '1;
    localparam logic [W-1:0] FIRST_GUESS = ALL_ONES >> 1;

    state_t        state_q, state_d;
    logic [W-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [W-1:0]  guess_d, found_d;
    logic [SW-1:0] steps_d;
    logic          done_d, fail_d;
    logic [W-1:0]  guess_dn, guess_up;
    logic          hit_x, hit_y, hit_z;

    // Sum is formed at W+1 bits so lo+hi cannot wrap before the halving.
    function automatic logic [W-1:0] midpoint(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(({1'b0, a} + {1'b0, b}) >> 1);
    endfunction

    assign guess_dn = guess - W'(1);
    assign guess_up = guess + W'(1);

`ifdef CMP_SEARCH_ONEHOT_CHECK_EN
    logic onehot;
    // Odd parity excludes 0 and 2 bits set; the AND term excludes all three.
    assign onehot = (res_x ^ res_y ^ res_z) & ~(res_x & res_y & res_z);
    assign hit_z  = onehot & res_z;
    assign hit_x  = onehot & res_x;
    assign hit_y  = onehot & res_y;
`else
    assign hit_z  = res_z;
    assign hit_x  = ~res_z & res_x;
    assign hit_y  = ~res_z & ~res_x & res_y;
`endif

    assign busy    = (state_q == REQ);
    assign cmp_req = (state_q == REQ);

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess;
        found_d = found;
        steps_d = steps;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = ALL_ONES;
                    guess_d = FIRST_GUESS;
                    steps_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cmp_ack) begin
                    steps_d = steps + SW'(1);
                    state_d = IDLE;
                    if (hit_z) begin
                        found_d = guess;
                        done_d  = 1'b1;
                    end else if (hit_x) begin
                        // guess <= lo covers both guess==0 and guess-1 < lo.
                        if (guess <= lo_q) begin
                            fail_d = 1'b1;
                        end else begin
                            hi_d    = guess_dn;
                            guess_d = midpoint(lo_q, guess_dn);
                            state_d = REQ;
                        end
                    end else if (hit_y) begin
                        // guess >= hi covers both guess==max and guess+1 > hi.
                        if (guess >= hi_q) begin
                            fail_d = 1'b1;
                        end else begin
                            lo_d    = guess_up;
                            guess_d = midpoint(guess_up, hi_q);
                            state_d = REQ;
                        end
                    end else begin
                        fail_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            guess   <= '0;
            found   <= '0;
            steps   <= '0;
            done    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess   <= guess_d;
            found   <= found_d;
            steps   <= steps_d;
            done    <= done_d;
            fail    <= fail_d;
        end
    end

endmodule

// File: tb/tb_cmp_search.sv
module tb_cmp_search;

    localparam int W    = 4;
    localparam int SW   = $clog2(W + 2);
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cmp_ack = 1'b0;
    logic          res_x = 1'b0, res_y = 1'b0, res_z = 1'b0;
    logic [W-1:0]  guess, found;
    logic          cmp_req, busy, done, fail;
    logic [SW-1:0] steps;

    cmp_search #(.W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .guess(guess), .cmp_req(cmp_req),
        .cmp_ack(cmp_ack), .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .busy(busy), .done(done), .fail(fail), .found(found), .steps(steps)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Search scenario shared by responder, model and checker.
    // mode 0: honest comparator, 1: always reports x, 2: first ack 3'b110 then honest.
    int target = 0, mode = 0, delay_mode = 0, resp_acks = 0;

    // Behavioural model: expected guess sequence and outcome of one search.
    int exp_q[$];
    bit exp_fail;
    int exp_found, exp_steps;
    int model_found = 0;

    task automatic response(input int g, input int md, input int k, input int tgt,
                            output bit x, output bit y, output bit z);
        if (md == 1) {x, y, z} = 3'b100;
        else if (md == 2 && k == 0) {x, y, z} = 3'b110;
        else begin
            x = (g > tgt); y = (g < tgt); z = (g == tgt);
        end
    endtask

    task automatic build_plan(input int tgt, input int md);
        int lo, hi, g, k;
        bit x, y, z, fin;
        exp_q.delete();
        lo = 0; hi = MAXV; g = (lo + hi) / 2; k = 0; fin = 0;
        exp_fail = 0; exp_found = 0;
        while (!fin) begin
            exp_q.push_back(g);
            response(g, md, k, tgt, x, y, z);
            k++;
`ifdef CMP_SEARCH_ONEHOT_CHECK_EN
            if (int'(x) + int'(y) + int'(z) != 1) begin exp_fail = 1; fin = 1; end else
`endif
            if (z) begin exp_found = g; fin = 1; end
            else if (x) begin
                if (g == 0 || g - 1 < lo) begin exp_fail = 1; fin = 1; end
                else begin hi = g - 1; g = (lo + hi) / 2; end
            end else if (y) begin
                if (g == MAXV || g + 1 > hi) begin exp_fail = 1; fin = 1; end
                else begin lo = g + 1; g = (lo + hi) / 2; end
            end else begin exp_fail = 1; fin = 1; end
        end
        exp_steps = k;
    endtask

    // Responder: drives the comparator side #1 after each rising edge.
    int  waited = 0, dly = 0;
    bit  rx, ry, rz;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_req) begin
                if (waited >= dly) begin
                    response(int'(guess), mode, resp_acks, target, rx, ry, rz);
                    cmp_ack = 1'b1;
                    {res_x, res_y, res_z} = {rx, ry, rz};
                    resp_acks++;
                    waited = 0;
                    dly = (delay_mode < 0) ? $urandom_range(0, 3) : delay_mode;
                end else begin
                    cmp_ack = 1'b0;
                    {res_x, res_y, res_z} = 3'($urandom_range(0, 7));
                    waited++;
                end
            end else begin
                // In IDLE the ack and result lines carry noise that must be ignored.
                cmp_ack = 1'($urandom_range(0, 1));
                {res_x, res_y, res_z} = 3'($urandom_range(0, 7));
                waited = 0;
                dly = (delay_mode < 0) ? $urandom_range(0, 3) : delay_mode;
            end
        end
    end

    // Compare process: checks DUT outputs against the model on every falling edge.
    bit pending = 0, active = 0;
    int acks_seen = 0, cyc_in = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pending && busy) begin
                active = 1; pending = 0; acks_seen = 0; cyc_in = 0;
            end
            if (active) begin
                if (busy) begin
                    chk("cmp_req_busy", int'(cmp_req), 1);
                    chk("done_low", int'(done), 0);
                    chk("fail_low", int'(fail), 0);
                    chk("steps_run", int'(steps), acks_seen);
                    if (acks_seen < exp_q.size()) begin
                        chk("guess", int'(guess), exp_q[acks_seen]);
                    end else begin
                        chk("busy_after_last_ack", int'(busy), 0);
                        active = 0;
                    end
                    if (cmp_ack) acks_seen++;
                    cyc_in++;
                    if (active && cyc_in > 200) begin
                        chk("search_cycle_budget", cyc_in, 200);
                        active = 0;
                    end
                end else begin
                    chk("end_ack_count", acks_seen, exp_q.size());
                    chk("done_pulse", int'(done), exp_fail ? 0 : 1);
                    chk("fail_pulse", int'(fail), exp_fail ? 1 : 0);
                    chk("cmp_req_end", int'(cmp_req), 0);
                    if (!exp_fail) model_found = exp_found;
                    chk("found_end", int'(found), model_found);
                    chk("steps_end", int'(steps), exp_steps);
                    active = 0;
                end
            end else begin
                chk("idle_busy", int'(busy), 0);
                chk("idle_cmp_req", int'(cmp_req), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_fail", int'(fail), 0);
                chk("idle_found", int'(found), model_found);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!active && !pending) break;
            @(negedge clk);
            #2;
        end
        if (active || pending) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: search still open after 400 cycles (active=%0d pending=%0d)",
                     active, pending);
            active = 0;
            pending = 0;
        end
    endtask

    // Launches a search; start is raised mid-cycle and held for hold extra cycles.
    task automatic run_search(input int tgt, input int md, input int dm, input int hold);
        wait_idle();
        target = tgt; mode = md; delay_mode = dm; resp_acks = 0;
        build_plan(tgt, md);
        pending = 1;
        start = 1'b1;
        @(posedge clk);
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_guess", int'(guess), 0);
        chk("rst_cmp_req", int'(cmp_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_steps", int'(steps), 0);
        #2 rst_n = 1'b1;

        // Pin the model against hand-derived sequences.
        build_plan(11, 0);
        chk("model_t11_len", exp_q.size(), 2);
        chk("model_t11_g0", exp_q[0], 7);
        chk("model_t11_g1", exp_q[1], 11);
        build_plan(0, 0);
        chk("model_t0_len", exp_q.size(), 4);
        chk("model_t0_g3", exp_q[3], 0);
        build_plan(15, 0);
        chk("model_t15_steps", exp_steps, W + 1);
        chk("model_t15_g3", exp_q[3], 14);
        build_plan(9, 1);
        chk("model_allx_fail", int'(exp_fail), 1);
        chk("model_allx_g2", exp_q[2], 1);

        // Directed searches with ack tied high.
        run_search(11, 0, 0, 0);
        wait_idle();
        chk("t11_found", int'(found), 11);
        chk("t11_steps", int'(steps), 2);
        run_search(0, 0, 0, 0);
        wait_idle();
        chk("t0_found", int'(found), 0);
        chk("t0_steps", int'(steps), 4);
        run_search(15, 0, 0, 0);
        wait_idle();
        chk("t15_found", int'(found), 15);
        chk("t15_steps", int'(steps), 5);

        // Delayed ack, start held high while busy.
        run_search(5, 0, 3, 4);
        wait_idle();
        chk("t5_found", int'(found), 5);
        chk("t5_steps", int'(steps), 3);

        // Inconsistent responder: fail, found keeps 5.
        run_search(9, 1, 0, 0);
        wait_idle();
        chk("allx_found_kept", int'(found), 5);
        chk("allx_steps", int'(steps), 4);

        // Non-one-hot first result.
        run_search(2, 2, 0, 0);
        wait_idle();
`ifdef CMP_SEARCH_ONEHOT_CHECK_EN
        chk("x110_found_kept", int'(found), 5);
        chk("x110_steps", int'(steps), 1);
`else
        chk("x110_found", int'(found), 2);
        chk("x110_steps", int'(steps), 4);
`endif

        // Random targets, random ack latency, back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            run_search($urandom_range(0, MAXV), ($urandom_range(0, 7) == 0) ? 1 : 0, -1, 0);
        end
        wait_idle();

        // Reset mid-search with start held high.
        target = 6; mode = 0; delay_mode = 3; resp_acks = 0;
        build_plan(6, 0);
        pending = 1;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        chk("busy_before_rst", int'(busy), 1);
        pending = 0;
        active = 0;
        rst_n = 1'b0;
        #1;
        model_found = 0;
        chk("arst_guess", int'(guess), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cmp_req", int'(cmp_req), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_fail", int'(fail), 0);
        chk("arst_found", int'(found), 0);
        chk("arst_steps", int'(steps), 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_search(13, 0, -1, 2);
        wait_idle();
        chk("post_rst_found", int'(found), 13);
        chk("post_rst_steps", int'(steps), 3);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
